reset_sequencer: RTL and testbench

Parametrised reset sequencer that replaces the ad-hoc power-on counter in SoC top levels. It synchronises the PLL lock indication and holds all cores in reset for a programmable number of cycles. It then releases N per-core reset channels in staggered order and re-sequences on lock loss or on a software/watchdog request. It sits between the clock generator and the multi-core SoC top level, clocked by the SoC clock.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/reset_seq_sync.sv | 25 ++
 rtl/reset_sequencer.sv | 153 +++++++++++++++
 tb/tb_reset_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types, reset values and counter sizing for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic RST_ASSERTED  = 1'b1;
  localparam logic RUNNING_RESET = 1'b0;
  localparam logic WD_FIRE_RESET = 1'b0;
  localparam logic SYNC_RESET    = 1'b0;

  // One counter width covers the hold time, the last release slot and the watchdog limit.
  function automatic int cnt_width(input int hold, input int channels,
                                   input int stagger, input int watchdog);
    int m;
    m = hold;
    if ((channels - 1) * stagger + 1 > m) m = (channels - 1) * stagger + 1;
    if (watchdog > m) m = watchdog;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Multi-flop synchroniser for the asynchronous PLL lock level; clears to 0 on reset.
module reset_seq_sync
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic synced
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= {SYNC_STAGES{SYNC_RESET}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], level};
    end
  end

  assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staggered per-core reset release with lock-loss and soft re-sequencing.
// Optional watchdog enabled by defining RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int HOLD_CYCLES     = 63,
  parameter int STAGGER_CYCLES  = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iLocked,
  input  logic                iSoftReset,
  input  logic                iKick,
  output logic [CHANNELS-1:0] oReset,
  output logic                oRunning,
  output logic                oWdFire
);

  localparam int               CNT_W       = cnt_width(HOLD_CYCLES, CHANNELS,
                                                       STAGGER_CYCLES, WATCHDOG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_SLOT   = CNT_W'((CHANNELS - 1) * STAGGER_CYCLES);
  localparam bit               ALL_AT_ONCE = (STAGGER_CYCLES == 0) || (CHANNELS == 1);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
  logic [CHANNELS-1:0] reset_next;
  logic                running_next;
  logic                fire_next;
  logic                lock_sync;
  logic                wd_expire;

  reset_seq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (Clock),
    .rst   (Reset),
    .level (iLocked),
    .synced(lock_sync)
  );

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG_CYCLES - 1);
  logic [CNT_W-1:0] wd_cnt, wd_cnt_next;

  always_comb begin
    wd_cnt_next = '0;
    wd_expire   = 1'b0;
    if (state == RUN && !iKick) begin
      if (wd_cnt == WD_LAST) wd_expire = 1'b1;
      else                   wd_cnt_next = wd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) wd_cnt <= '0;
    else       wd_cnt <= wd_cnt_next;
  end
`else
  logic unused_kick;
  assign unused_kick = iKick;
  assign wd_expire   = 1'b0;
`endif

  // Saturating so a long hold can never wrap back into an early release.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    reset_next   = oReset;
    running_next = oRunning;
    fire_next    = 1'b0;

    if (state != WAIT_LOCK && !lock_sync) begin
      state_next   = WAIT_LOCK;
      cnt_next     = '0;
      reset_next   = {CHANNELS{RST_ASSERTED}};
      running_next = RUNNING_RESET;
    end else if ((state == RELEASE || state == RUN) && (iSoftReset || wd_expire)) begin
      state_next   = HOLD;
      cnt_next     = '0;
      reset_next   = {CHANNELS{RST_ASSERTED}};
      running_next = RUNNING_RESET;
      fire_next    = wd_expire;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt_next     = '0;
          reset_next   = {CHANNELS{RST_ASSERTED}};
          running_next = RUNNING_RESET;
          if (lock_sync) state_next = HOLD;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt_next = '0;
            if (ALL_AT_ONCE) begin
              reset_next   = '0;
              running_next = 1'b1;
              state_next   = RUN;
            end else begin
              reset_next[0] = 1'b0;
              state_next    = RELEASE;
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end
        RELEASE: begin
          cnt_next = cnt_inc;
          for (int k = 1; k < CHANNELS; k++) begin
            if (cnt_inc >= CNT_W'(k * STAGGER_CYCLES)) reset_next[k] = 1'b0;
          end
          if (cnt_inc >= LAST_SLOT) begin
            running_next = 1'b1;
            state_next   = RUN;
          end
        end
        RUN: begin
          reset_next   = '0;
          running_next = 1'b1;
        end
        default: begin
          state_next   = WAIT_LOCK;
          cnt_next     = '0;
          reset_next   = {CHANNELS{RST_ASSERTED}};
          running_next = RUNNING_RESET;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      oReset   <= {CHANNELS{RST_ASSERTED}};
      oRunning <= RUNNING_RESET;
      oWdFire  <= WD_FIRE_RESET;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      oReset   <= reset_next;
      oRunning <= running_next;
      oWdFire  <= fire_next;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline model plus directed literal checkpoints.
module tb_reset_sequencer;

  localparam int C  = 4;
  localparam int H  = 63;
  localparam int S  = 4;
  localparam int SS = 2;
  localparam int WD = 16;
`ifdef RESET_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         iLocked = 1'b0;
  logic         iSoftReset = 1'b0;
  logic         iKick = 1'b0;
  logic [C-1:0] oReset;
  logic         oRunning;
  logic         oWdFire;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  reset_sequencer #(
    .CHANNELS       (C),
    .HOLD_CYCLES    (H),
    .STAGGER_CYCLES (S),
    .SYNC_STAGES    (SS),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iLocked   (iLocked),
    .iSoftReset(iSoftReset),
    .iKick     (iKick),
    .oReset    (oReset),
    .oRunning  (oRunning),
    .oWdFire   (oWdFire)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  // Model: a sequence is described only by the edge it entered HOLD (e_start).
  int  e_start   = -1;
  int  last_kick = -1;
  bit  ls_q[$];
  bit  exp_fire  = 1'b0;

  initial for (int i = 0; i < SS; i++) ls_q.push_back(1'b0);

  always @(posedge Clock or posedge Reset) begin : model
    int n, run_at, base;
    bit ls, in_rel_run, in_run;
    if (Reset) begin
      e_start  = -1;
      exp_fire = 1'b0;
      ls_q.delete();
      for (int i = 0; i < SS; i++) ls_q.push_back(1'b0);
    end else begin
      n  = cyc + 1;
      ls = ls_q[0];
      void'(ls_q.pop_front());
      ls_q.push_back(iLocked);
      exp_fire = 1'b0;
      if (e_start >= 0) begin
        run_at     = e_start + H + (C - 1) * S;
        in_rel_run = (n - 1 - e_start) >= H;
        in_run     = (n - 1) >= run_at;
        base       = (last_kick > run_at) ? last_kick : run_at;
        if (!ls) e_start = -1;
        else if (WD_EN && in_run && !iKick && (n - base) == WD) begin
          exp_fire = 1'b1;
          e_start  = n;
        end else if (in_rel_run && iSoftReset) e_start = n;
      end else if (ls) begin
        e_start = n;
      end
      if (iKick) last_kick = n;
    end
  end

  function automatic logic [C-1:0] exp_reset();
    logic [C-1:0] r;
    for (int k = 0; k < C; k++)
      r[k] = !(e_start >= 0 && (cyc - e_start) >= H + k * S);
    return r;
  endfunction

  function automatic logic exp_running();
    return e_start >= 0 && (cyc - e_start) >= H + (C - 1) * S;
  endfunction

  always @(negedge Clock) begin
    chk("model_reset", 32'(oReset), 32'(exp_reset()));
    chk("model_running", 32'(oRunning), 32'(exp_running()));
    chk("model_wdfire", 32'(oWdFire), 32'(exp_fire));
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic lit(input string name, input logic [C-1:0] r, input logic run);
    chk({name, "_reset"}, 32'(oReset), 32'(r));
    chk({name, "_running"}, 32'(oRunning), 32'(run));
  endtask

  initial begin : timeout
    #20000;
    $display("FAIL timeout cycle=%0d got=running want=finished", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    goto(3);
    lit("por", 4'b1111, 1'b0);
    chk("por_wdfire", 32'(oWdFire), 32'd0);
    goto(5);  Reset = 1'b0;
    goto(9);  iLocked = 1'b1;
    goto(74); lit("up74", 4'b1111, 1'b0);
    goto(75); lit("up75", 4'b1110, 1'b0);
    goto(79); lit("up79", 4'b1100, 1'b0);
    goto(83); lit("up83", 4'b1000, 1'b0);
    goto(86); lit("up86", 4'b1000, 1'b0);
    goto(87); lit("up87", 4'b0000, 1'b1);

    // One-cycle lock drop, then relock and full sequence again.
    goto(100); iLocked = 1'b0;
    goto(101); iLocked = 1'b1;
    goto(102); lit("ll102", 4'b0000, 1'b1);
    goto(103); lit("ll103", 4'b1111, 1'b0);
    goto(166); lit("ll166", 4'b1111, 1'b0);
    goto(167); lit("ll167", 4'b1110, 1'b0);
    goto(179); lit("ll179", 4'b0000, 1'b1);

    // Soft abort in RUN, then during RELEASE, plus an ignored request in HOLD.
    goto(184); iSoftReset = 1'b1;
    goto(185); iSoftReset = 1'b0;
    lit("sr185", 4'b1111, 1'b0);
    goto(252); lit("sr252", 4'b1100, 1'b0);
    iSoftReset = 1'b1;
    goto(253); iSoftReset = 1'b0;
    lit("sr253", 4'b1111, 1'b0);
    goto(269); iSoftReset = 1'b1;
    goto(270); iSoftReset = 1'b0;
    goto(315); lit("sr315", 4'b1111, 1'b0);
    goto(316); lit("sr316", 4'b1110, 1'b0);
    goto(328); lit("sr328", 4'b0000, 1'b1);

    // Lock loss and soft request on the same cycle: lock loss wins.
    goto(339); iLocked = 1'b0;
    goto(340); iLocked = 1'b1;
    goto(341); iSoftReset = 1'b1;
    goto(342); iSoftReset = 1'b0;
    lit("sim342", 4'b1111, 1'b0);
    goto(405); lit("sim405", 4'b1111, 1'b0);
    goto(406); lit("sim406", 4'b1110, 1'b0);

    // Asynchronous reset between edges in the middle of RELEASE.
    goto(410);
    #2 Reset = 1'b1;
    #1 lit("async", 4'b1111, 1'b0);
    #2 Reset = 1'b0;
    goto(475); lit("ar475", 4'b1111, 1'b0);
    goto(476); lit("ar476", 4'b1110, 1'b0);
    goto(488); lit("ar488", 4'b0000, 1'b1);

    // Regular kicks, then silence until the watchdog limit.
    for (int i = 0; i < 9; i++) begin
      goto(490 + 10 * i); iKick = 1'b1;
      goto(491 + 10 * i); iKick = 1'b0;
    end
    goto(586);
    lit("wd586", 4'b0000, 1'b1);
    chk("wd586_fire", 32'(oWdFire), 32'd0);
    goto(587);
    if (WD_EN) begin
      lit("wd587", 4'b1111, 1'b0);
      chk("wd587_fire", 32'(oWdFire), 32'd1);
    end else begin
      lit("wd587", 4'b0000, 1'b1);
      chk("wd587_fire", 32'(oWdFire), 32'd0);
    end
    goto(588);
    chk("wd588_fire", 32'(oWdFire), 32'd0);
    goto(660);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
